// File: rtl/subtractor_32_seq.sv
// Multi-cycle WIDTH-bit subtractor: diff = in1 - in2 - bin, SLICE bits per cycle, LSB first.
// Optional SUB32_FLAGS_EN adds zero/neg/ovf result flags.

module subtractor_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);
    // Extra MSB of the widened difference is the borrow out of this slice
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
endmodule

module subtractor_32_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB32_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_q, b_q, diff_q, diff_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic               borrow_q, borrow_nxt, bout_q;
    logic [SLICE-1:0]   a_sl, b_sl, d_sl;
    logic               last_slice;

    assign a_sl       = a_q[cnt_q*SLICE +: SLICE];
    assign b_sl       = b_q[cnt_q*SLICE +: SLICE];
    assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

    subtractor_slice #(.W(SLICE)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .bin  (borrow_q),
        .d    (d_sl),
        .bout (borrow_nxt)
    );

    always_comb begin
        state_nxt = state;
        diff_nxt  = diff_q;
        diff_nxt[cnt_q*SLICE +: SLICE] = d_sl;
        case (state)
            IDLE:    if (in_valid)   state_nxt = CALC;
            CALC:    if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= in1;
                    b_q      <= in2;
                    borrow_q <= bin;
                    cnt_q    <= '0;
                end
                CALC: begin
                    diff_q   <= diff_nxt;
                    borrow_q <= borrow_nxt;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_slice) bout_q <= borrow_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SUB32_FLAGS_EN
    // Flags come from the completed diff, captured on the same edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            neg  <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == CALC && last_slice) begin
            zero <= (diff_nxt == '0);
            neg  <= diff_nxt[WIDTH-1];
            ovf  <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_nxt[WIDTH-1]);
        end
    end
`endif

endmodule

// File: tb/tb_subtractor_32_seq.sv
// Randomized self-checking bench for subtractor_32_seq against an arithmetic reference model.
// Build with +define+SUB32_FLAGS_EN to also check zero/neg/ovf.

module tb_subtractor_32_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in1, in2;
    logic        bin;
    logic        out_valid, out_ready;
    logic [31:0] diff;
    logic        bout;
`ifdef SUB32_FLAGS_EN
    logic        zero, neg, ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    subtractor_32_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB32_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accept one operation; returns at the negedge following the accept edge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic c);
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        in1 = a; in2 = b; bin = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in1 = $urandom; in2 = $urandom; bin = 1'($urandom);
        chk("in_ready_calc", 64'(in_ready), 64'd0);
    endtask

    task automatic finish_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                             input int hold);
        logic [31:0] e_diff;
        logic        e_bout;
        logic        e_ovf;
        longint      s;
        int          lat;
        e_diff = a - b - 32'(c);
        e_bout = (64'(a) < 64'(b) + 64'(c));
        s      = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
        e_ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("diff", 64'(diff), 64'(e_diff));
        chk("bout", 64'(bout), 64'(e_bout));
`ifdef SUB32_FLAGS_EN
        chk("zero", 64'(zero), 64'(e_diff == 32'd0));
        chk("neg",  64'(neg),  64'(e_diff[31]));
        chk("ovf",  64'(ovf),  64'(e_ovf));
`else
        if (e_ovf && hold < 0) $display("note: unreachable");
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); in1 = $urandom; in2 = $urandom;
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_diff",  64'(diff), 64'(e_diff));
            chk("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("handoff_valid", 64'(out_valid), 64'd0);
        chk("handoff_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input int hold);
        start_op(a, b, c);
        finish_op(a, b, c, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; bin = 1'b0;
        #12;
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff",      64'(diff), 64'd0);
        chk("rst_bout",      64'(bout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h0000_0010, 32'h0000_0001, 1'b0, 0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        // Long back-pressure with in_valid noise
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 10);

        // Reset in the 2nd CALC cycle aborts the operation
        start_op(32'hCAFE_0000, 32'h0000_1234, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready",  64'(in_ready), 64'd1);
        chk("abort_diff",      64'(diff), 64'd0);
`ifdef SUB32_FLAGS_EN
        chk("abort_zero", 64'(zero), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h0000_1000, 32'h0000_2000, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (n % 8 == 1) b = a;
            if (n % 8 == 2) a = {1'b1, a[30:0]};
            run_op(a, b, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
